// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine refund path: coin values in
// 50-won units, denomination indices and the dispenser FSM states.
package vm_pkg;

   localparam logic [6:0] COIN50_U   = 7'd1;
   localparam logic [6:0] COIN100_U  = 7'd2;
   localparam logic [6:0] COIN500_U  = 7'd10;
   localparam logic [6:0] COIN1000_U = 7'd20;

   // Index order matches the LoadSel encoding used by the controller
   typedef enum logic [1:0] {
      DEN_50   = 2'd0,
      DEN_100  = 2'd1,
      DEN_500  = 2'd2,
      DEN_1000 = 2'd3
   } denom_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PULSE,
      ST_GAP,
      ST_FINISH
   } state_e;

   function automatic logic [6:0] coin_units(input denom_e den);
      logic [6:0] units;
      case (den)
         DEN_50:   units = COIN50_U;
         DEN_100:  units = COIN100_U;
         DEN_500:  units = COIN500_U;
         default:  units = COIN1000_U;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/coin_inventory.sv
// Four 8-bit coin counters: overwrite on load, saturating +1 on deposit,
// -1 on dispense, with per-denomination nonzero flags for change selection.
module coin_inventory import vm_pkg::*; #(
   parameter int unsigned INV_RESET = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_en,
   input  logic [1:0] load_sel,
   input  logic [7:0] load_count,
   input  logic [3:0] deposit,
   input  logic       dec_en,
   input  denom_e     dec_idx,
   output logic [3:0] nonzero
);

   logic [3:0][7:0] count_q;
   logic [3:0][7:0] count_d;

   // A deposit and a dispense of the same coin in one cycle cancel out
   always_comb begin
      count_d = count_q;
      for (int i = 0; i < 4; i++) begin
         if (load_en && (load_sel == 2'(i))) begin
            count_d[i] = load_count;
         end else if (deposit[i] && !(dec_en && (dec_idx == 2'(i)))) begin
            if (count_q[i] != 8'hFF) begin
               count_d[i] = count_q[i] + 8'd1;
            end
         end else if (!deposit[i] && dec_en && (dec_idx == 2'(i))) begin
            count_d[i] = count_q[i] - 8'd1;
         end
      end
   end

   always_comb begin
      nonzero = '0;
      for (int i = 0; i < 4; i++) begin
         nonzero[i] = (count_q[i] != 8'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {4{8'(INV_RESET)}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Refund stage: pays out an accepted amount as a greedy series of one-cycle
// coin-eject pulses, limited by the coins currently held in inventory.
module change_dispenser import vm_pkg::*; #(
   parameter int unsigned PULSE_GAP = 1,
   parameter int unsigned INV_RESET = 10
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Req,
   input  logic [6:0] Amount,
   output logic       Ready,
   input  logic       Load,
   input  logic [1:0] LoadSel,
   input  logic [7:0] LoadCount,
   input  logic       Deposit50,
   input  logic       Deposit100,
   input  logic       Deposit500,
   input  logic       Deposit1000,
   output logic       Return50,
   output logic       Return100,
   output logic       Return500,
   output logic       Return1000,
   output logic       Done,
   output logic       Short,
   output logic [6:0] Remain
);

   localparam logic [3:0] GAP_LAST = 4'(PULSE_GAP - 1);

   state_e     state_q, state_d;
   logic [6:0] remain_q, remain_d;
   logic       short_q, short_d;
   denom_e     sel_q, sel_d;
   logic [3:0] gap_q, gap_d;
   logic       dec_en;
   logic [3:0] inv_nonzero;

   coin_inventory #(
      .INV_RESET (INV_RESET)
   ) u_inv (
      .clk        (CLK),
      .rst        (RST),
      .load_en    (Load && (state_q == ST_IDLE)),
      .load_sel   (LoadSel),
      .load_count (LoadCount),
      .deposit    ({Deposit1000, Deposit500, Deposit100, Deposit50}),
      .dec_en     (dec_en),
      .dec_idx    (sel_q),
      .nonzero    (inv_nonzero)
   );

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      short_d  = short_q;
      sel_d    = sel_q;
      gap_d    = gap_q;
      dec_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Req) begin
               remain_d = Amount;
               short_d  = 1'b0;
               state_d  = ST_SELECT;
            end
         end
         ST_SELECT: begin
            // Largest coin that fits and is in stock; none means we are stuck
            if (remain_q == 7'd0) begin
               state_d = ST_FINISH;
            end else if ((remain_q >= COIN1000_U) && inv_nonzero[DEN_1000]) begin
               sel_d   = DEN_1000;
               state_d = ST_PULSE;
            end else if ((remain_q >= COIN500_U) && inv_nonzero[DEN_500]) begin
               sel_d   = DEN_500;
               state_d = ST_PULSE;
            end else if ((remain_q >= COIN100_U) && inv_nonzero[DEN_100]) begin
               sel_d   = DEN_100;
               state_d = ST_PULSE;
            end else if (inv_nonzero[DEN_50]) begin
               sel_d   = DEN_50;
               state_d = ST_PULSE;
            end else begin
               state_d = ST_FINISH;
            end
         end
         ST_PULSE: begin
            remain_d = remain_q - coin_units(sel_q);
            dec_en   = 1'b1;
            gap_d    = 4'd0;
            state_d  = (PULSE_GAP != 0) ? ST_GAP : ST_SELECT;
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = 4'd0;
               state_d = ST_SELECT;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         ST_FINISH: begin
            if (remain_q != 7'd0) begin
               short_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         remain_q <= 7'd0;
         short_q  <= 1'b0;
         sel_q    <= DEN_50;
         gap_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         short_q  <= short_d;
         sel_q    <= sel_d;
         gap_q    <= gap_d;
      end
   end

   // Short is already visible alongside Done, then held by short_q
   assign Ready      = (state_q == ST_IDLE);
   assign Done       = (state_q == ST_FINISH);
   assign Short      = short_q | (Done && (remain_q != 7'd0));
   assign Remain     = remain_q;
   assign Return50   = (state_q == ST_PULSE) && (sel_q == DEN_50);
   assign Return100  = (state_q == ST_PULSE) && (sel_q == DEN_100);
   assign Return500  = (state_q == ST_PULSE) && (sel_q == DEN_500);
   assign Return1000 = (state_q == ST_PULSE) && (sel_q == DEN_1000);

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Refund/change stage directly downstream of the coffee vending controller. Accepts a refund amount (units of 50 won) via a ready/request handshake, dispenses it as a greedy sequence of one-cycle coin pulses (1000/500/100/50), and tracks per-denomination coin inventory. Drives the Return50/100/500/1000 coin-eject lines. Inventory is fed by the controller's accepted-coin strobes and by manage-mode loads.

## Interface
Parameters:
- PULSE_GAP, 1: idle cycles inserted after each coin pulse (eject mechanism recovery), 0..15.
- INV_RESET, 10: inventory count of every denomination after reset, 0..255.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- Req  in  1  refund request; accepted when Req && Ready.
- Amount  in  7  refund value in units of 50 won; sampled on acceptance.
- Ready  out  1  high in IDLE only.
- Load  in  1  inventory load strobe; honoured only in IDLE.
- LoadSel  in  2  0=50, 1=100, 2=500, 3=1000.
- LoadCount  in  8  value written to selected inventory.
- Deposit50, Deposit100, Deposit500, Deposit1000  in  1 each  accepted-coin strobes; +1 to that inventory.
- Return50, Return100, Return500, Return1000  out  1 each  one-cycle coin-eject pulse.
- Done  out  1  one-cycle pulse, refund finished.
- Short  out  1  exact change not possible; held until next accepted Req.
- Remain  out  7  undispensed amount; held after finish.

## Operation
- Coin values in units: 50=1, 100=2, 500=10, 1000=20.
- FSM states: IDLE, SELECT, PULSE, GAP, FINISH.
- IDLE: Ready=1. On Req: Remain<=Amount, Short<=0, go SELECT.
- SELECT: if Remain==0 -> FINISH. Else pick largest denomination with value<=Remain and inventory>0 -> PULSE. If none qualifies -> FINISH.
- PULSE: assert selected Return* for exactly this cycle; Remain -= value; that inventory -= 1. Next: GAP if PULSE_GAP>0, else SELECT.
- GAP: count PULSE_GAP cycles, then SELECT.
- FINISH: Done=1; Short=1 if Remain!=0; next IDLE.
- Inventory: four 8-bit counters. Deposit saturates at 255. Deposit and decrement of same counter in same cycle: net unchanged. Load in IDLE overwrites selected counter; Load has priority over a same-cycle Deposit to that counter. Load outside IDLE ignored.
- Req outside IDLE ignored (Ready low); Amount changes after acceptance have no effect.
- Remain arithmetic 7-bit unsigned; greedy selection guarantees no underflow.

## Timing
- Reset values: Ready=1 (IDLE), Return*=0, Done=0, Short=0, Remain=0, GAP counter=0, all inventories=INV_RESET.
- RST mid-refund: abort immediately; no further pulses; no Done; state as above next cycle.
- Req accepted at edge T: SELECT in T+1, first PULSE in T+2.
- Pulse spacing: 2+PULSE_GAP cycles (PULSE, GAP×PULSE_GAP, SELECT).
- N coins dispensed: Done in cycle T+1+N×(2+PULSE_GAP)+1; Ready again the cycle after Done.
- Amount=0: SELECT T+1, Done T+2, no pulses.
- At most one Return* high in any cycle; Return* never high outside PULSE.

## Structure
- Shared package vm_pkg: coin unit constants (COIN50_U..COIN1000_U), denomination index typedef (2-bit, order 50/100/500/1000 matching LoadSel), FSM state enum.
- One sub-module: coin_inventory — four saturating 8-bit counters with load, deposit, decrement-by-index, and per-denomination nonzero flags. Selection logic and FSM stay in change_dispenser.

## Test plan
- Reset, PULSE_GAP=1, Req Amount=3 at T -> Return100 at T+2, Return50 at T+5, Done at T+8, Short=0, Remain=0, inv100=9, inv50=9.
- Amount=33 -> pulses in order Return1000, Return500, Return100, Return50, 3 cycles apart; Done after 4th; all four inventories=9.
- Load inv100=0, inv50=1 (others 0); Amount=4 -> single Return50, Done, Short=1, Remain=3; next Req clears Short.
- Amount=0 -> Done at T+2, no Return*; Req while Busy and Load while Busy ignored (inventory unchanged).
- Deposit100 in same cycle as Return100 pulse -> inv100 unchanged; Deposit50 with inv50=255 -> stays 255; Load and Deposit same counter in IDLE -> LoadCount wins.
- RST asserted between 1st and 2nd pulse of Amount=33 -> no further Return*, no Done, Ready=1 and inventories=INV_RESET next cycle.
